// File: rtl/l2_resp_buf_pkg.sv
// Shared types, defaults and width helpers for the L2 response credit buffer.
package l2_resp_buf_pkg;

  localparam int unsigned DEFAULT_DEPTH      = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 64;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] rdata;
  } resp_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the counter can hold the value DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/l2_resp_fifo_mem.sv
// DEPTH x DATA_WIDTH register file: one synchronous write port, one asynchronous read port.
module l2_resp_fifo_mem
  import l2_resp_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  localparam int unsigned ADDR_W    = ptr_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/l2_resp_credit_buffer.sv
// Per-master response FIFO with outstanding-request credit throttling.
// Optional zero-latency pass-through when L2_RESP_BUF_BYPASS_EN is defined.
module l2_resp_credit_buffer
  import l2_resp_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  localparam int unsigned CNT_W     = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_gnt_o,
  output logic                  req_valid_o,
  input  logic                  req_gnt_i,
  input  logic                  data_r_valid_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
  output logic                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  input  logic                  data_r_ready_i,
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  proto_err_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d, outst_q, outst_d, in_flight;
  logic                  err_q, err_d;
  logic                  credit_avail, accept;
  logic                  fifo_empty, fifo_full, fifo_pop, resp_pop;
  logic                  bypass, push, overflow, unexpected;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign credit_avail = (outst_q < CNT_W'(DEPTH));
  assign req_valid_o  = req_valid_i & credit_avail;
  assign req_gnt_o    = req_gnt_i & credit_avail;
  assign accept       = req_valid_o & req_gnt_i;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));

`ifdef L2_RESP_BUF_BYPASS_EN
  assign bypass = fifo_empty & data_r_valid_i & data_r_ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_pop = ~fifo_empty & data_r_ready_i;
  assign resp_pop = fifo_pop | bypass;
  // A pop frees the slot this edge, so a full FIFO can still accept a push.
  assign push       = data_r_valid_i & ~bypass & (~fifo_full | fifo_pop);
  assign overflow   = data_r_valid_i & fifo_full & ~fifo_pop;
  assign in_flight  = outst_q - count_q;
  assign unexpected = data_r_valid_i & (in_flight == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    outst_d  = outst_q;
    err_d    = err_q | overflow | unexpected;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push && !fifo_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (fifo_pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    // Saturate at zero: a pop of an unexpected response has no credit to return.
    if (accept && !resp_pop) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (resp_pop && !accept && (outst_q != '0)) begin
      outst_d = outst_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
    end
  end

  l2_resp_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_r_rdata_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign data_r_valid_o = ~fifo_empty | bypass;
  assign data_r_rdata_o = bypass     ? data_r_rdata_i :
                          fifo_empty ? '0             : mem_rdata;
  assign outstanding_o  = outst_q;
  assign proto_err_o    = err_q;

endmodule
